// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: 20 ms frames, per-frame sampled and clamped pulse width.
// Optional slew limiting of width changes with SERVO_PWM_SLEW_LIMIT_EN.
module servo_pwm_gen #(
  parameter int unsigned PERIOD    = 2000000,
  parameter int unsigned WIDTH_MIN = 50000,
  parameter int unsigned WIDTH_MAX = 250000,
  parameter int unsigned NEUTRAL   = 145000,
  parameter int unsigned MAX_STEP  = 5000
) (
  input  logic        clk,
  input  logic        reset_servo_pwm_n,
  input  logic        enable_pwm,
  input  logic [17:0] width_in,
  output logic        pwm_out,
  output logic        frame_start,
  output logic [17:0] width_active,
  output logic        clamped
);

  localparam int unsigned CW = 21;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [17:0] WMIN = 18'(WIDTH_MIN);
  localparam logic [17:0] WMAX = 18'(WIDTH_MAX);
  localparam logic [17:0] WNEU = 18'(NEUTRAL);

  if (!(PERIOD > WIDTH_MAX && PERIOD <= 2**CW &&
        WIDTH_MIN >= 1 && WIDTH_MIN <= WIDTH_MAX &&
        WIDTH_MAX < 2**18 && MAX_STEP >= 1 &&
        NEUTRAL >= WIDTH_MIN && NEUTRAL <= WIDTH_MAX))
  begin : g_cfg_err
    $error("servo_pwm_gen: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [17:0]   width_q, width_d;
  logic          clamp_q, clamp_d;
  logic          pwm_q, pwm_d;
  logic          fs_q, fs_d;

  logic [17:0]   tgt;
  logic          tgt_clamp;
  logic [17:0]   next_w;

  always_comb begin
    tgt       = width_in;
    tgt_clamp = 1'b0;
    if (width_in < WMIN) begin
      tgt       = WMIN;
      tgt_clamp = 1'b1;
    end else if (width_in > WMAX) begin
      tgt       = WMAX;
      tgt_clamp = 1'b1;
    end
  end

`ifdef SERVO_PWM_SLEW_LIMIT_EN
  localparam logic [17:0] STEP = 18'(MAX_STEP);
  logic [17:0] up, dn;

  always_comb begin
    up     = tgt - width_q;
    dn     = width_q - tgt;
    next_w = width_q;
    if (tgt > width_q) begin
      next_w = width_q + ((up > STEP) ? STEP : up);
    end else if (tgt < width_q) begin
      next_w = width_q - ((dn > STEP) ? STEP : dn);
    end
  end
`else
  assign next_w = tgt;
`endif

  // Outputs are registered against the next counter value so that
  // pwm_out/frame_start line up with the counter of the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    clamp_d = clamp_q;
    pwm_d   = 1'b0;
    fs_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable_pwm) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        width_d = next_w;
        clamp_d = tgt_clamp;
        state_d = RUN;
        fs_d    = 1'b1;
        pwm_d   = (next_w != '0);
      end
      RUN: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (enable_pwm) begin
            width_d = next_w;
            clamp_d = tgt_clamp;
            fs_d    = 1'b1;
            pwm_d   = (next_w != '0);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          pwm_d = (cnt_d < {3'b000, width_q});
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_servo_pwm_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      width_q <= WNEU;
      clamp_q <= 1'b0;
      pwm_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      clamp_q <= clamp_d;
      pwm_q   <= pwm_d;
      fs_q    <= fs_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign frame_start  = fs_q;
  assign width_active = width_q;
  assign clamped      = clamp_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen: frame-level model feeds a queue,
// a monitor measures each frame's pulse and compares.
module tb_servo_pwm_gen;

  localparam int PERIOD   = 100;
  localparam int WMIN     = 10;
  localparam int WMAX     = 80;
  localparam int NEUTRAL  = 50;
  localparam int MAX_STEP = 15;
  localparam int NDIR     = 11;
  localparam int NRND     = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [17:0] win;
  logic        pwm;
  logic        fs;
  logic [17:0] wa;
  logic        cl;

  servo_pwm_gen #(
    .PERIOD(PERIOD),
    .WIDTH_MIN(WMIN),
    .WIDTH_MAX(WMAX),
    .NEUTRAL(NEUTRAL),
    .MAX_STEP(MAX_STEP)
  ) dut (
    .clk(clk),
    .reset_servo_pwm_n(rst_n),
    .enable_pwm(en),
    .width_in(win),
    .pwm_out(pwm),
    .frame_start(fs),
    .width_active(wa),
    .clamped(cl)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit idle;
    int w;
    bit c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   w_m;
  bit   sb_hold = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Frame-level model: clamp then (optionally) move toward target in steps.
  task automatic push_frame(input int x);
    int   t;
    int   d;
    exp_t e;
    t = (x < WMIN) ? WMIN : ((x > WMAX) ? WMAX : x);
`ifdef SERVO_PWM_SLEW_LIMIT_EN
    d = t - w_m;
    if (d > MAX_STEP) d = MAX_STEP;
    if (d < -MAX_STEP) d = -MAX_STEP;
    w_m = w_m + d;
`else
    d = 0;
    w_m = t + d;
`endif
    e.idle = 1'b0;
    e.w    = w_m;
    e.c    = (x < WMIN) || (x > WMAX);
    q.push_back(e);
  endtask

  task automatic push_idle();
    exp_t e;
    e.idle = 1'b1;
    e.w    = 0;
    e.c    = 1'b0;
    q.push_back(e);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fs !== 1'b1 && n < 4 * PERIOD);
  endtask

  function automatic int rand_w();
    int bnd [6];
    int r;
    bnd = '{0, 9, 10, 80, 81, 262143};
    case ($urandom_range(0, 4))
      0: r = $urandom_range(0, 9);
      1: r = $urandom_range(81, 262143);
      2, 3: r = $urandom_range(10, 80);
      default: r = bnd[$urandom_range(0, 5)];
    endcase
    return r;
  endfunction

  initial begin : mon
    exp_t e;
    int   n;
    int   shape;
    int   fpos;
    int   wchg;
    while (!sb_hold) begin
      n = 0;
      while (fs !== 1'b1 && !sb_hold) begin
        @(negedge clk);
        n++;
        if (n == 4 * PERIOD) chk("frame timeout", 0, 1);
      end
      if (!sb_hold) begin
        if (q.size() == 0 || q[0].idle) begin
          chk("unexpected frame_start", 1, 0);
          if (q.size() != 0) void'(q.pop_front());
          e.idle = 1'b0;
          e.w    = 0;
          e.c    = 1'b0;
        end else begin
          e = q.pop_front();
        end
        chk("width_active", 32'(wa), e.w);
        chk("clamped", 32'(cl), 32'(e.c));
        shape = 0;
        fpos  = 0;
        wchg  = 0;
        for (int i = 0; i < PERIOD; i++) begin
          if (i > 0) @(negedge clk);
          if (sb_hold) break;
          if (pwm !== (i < e.w)) shape++;
          if (fs !== (i == 0)) fpos++;
          if (32'(wa) !== e.w) wchg++;
        end
        if (!sb_hold) begin
          chk("pulse shape errors", shape, 0);
          chk("frame_start position errors", fpos, 0);
          chk("width_active stability errors", wchg, 0);
          @(negedge clk);
          if (q.size() != 0 && q[0].idle) begin
            void'(q.pop_front());
            chk("idle pwm_out", 32'(pwm), 0);
            chk("idle frame_start", 32'(fs), 0);
          end else begin
            chk("frame length", 32'(fs), 1);
          end
        end
      end
    end
  end

  initial begin : stim
    int xs    [NDIR];
    int ks    [NDIR];
    bit drops [NDIR];
    int lat;
    int x;
    int k;
    bit drop;
    xs    = '{30, 5, 200, 40, 30, 60, 30, 50, 50, 80, 80};
    ks    = '{50, 40, 40, 40, 40, 15, 40, 0, 40, 40, 40};
    drops = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    rst_n = 1'b0;
    en    = 1'b1;
    win   = 18'd30;
    repeat (3) begin
      @(negedge clk);
      chk("reset pwm_out", 32'(pwm), 0);
      chk("reset frame_start", 32'(fs), 0);
      chk("reset width_active", 32'(wa), NEUTRAL);
      chk("reset clamped", 32'(cl), 0);
    end

    w_m = NEUTRAL;
    push_frame(30);
    rst_n = 1'b1;
    wait_fs(lat);
    chk("first frame latency", lat, 2);

    for (int i = 0; i < NDIR + NRND; i++) begin
      if (i < NDIR) begin
        x    = xs[i];
        k    = ks[i];
        drop = drops[i];
      end else begin
        x    = rand_w();
        k    = $urandom_range(2, 97);
        drop = ($urandom_range(0, 7) == 0);
      end
      if (drop) begin
        repeat (20) @(negedge clk);
        en = 1'b0;
        push_idle();
        repeat (20) @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (PERIOD - 40) @(negedge clk);
        win = 18'(x);
        push_frame(x);
        en = 1'b1;
        wait_fs(lat);
        chk("restart latency", lat, 2);
      end else begin
        @(negedge clk);
        win = 18'($urandom_range(0, 262143));
        repeat (k - 1) @(negedge clk);
        win = 18'(x);
        push_frame(x);
        wait_fs(lat);
        chk("frame period", lat, PERIOD - k);
      end
    end

    repeat (5) @(negedge clk);
    chk("pwm high before reset", 32'(pwm), 1);
    sb_hold = 1'b1;
    rst_n   = 1'b0;
    @(negedge clk);
    chk("mid-frame reset pwm_out", 32'(pwm), 0);
    chk("mid-frame reset frame_start", 32'(fs), 0);
    chk("mid-frame reset width_active", 32'(wa), NEUTRAL);
    chk("mid-frame reset clamped", 32'(cl), 0);
    chk("scoreboard drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
